// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch front-end
package fetch_pkg;

    // Bus transfer phases of the fetch sequencer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } fetch_state_t;

    // PC step per fetched instruction word
    localparam int FETCH_INC = 4;

    // Native width of a prefetch entry field on RV32
    localparam int FETCH_XLEN = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry circular prefetch FIFO
//
// Ports:
//   clk, rts          clock, synchronous active-high reset
//   push, push_data   write an entry at the tail
//   pop               drop the head entry
//   flush             empty the queue; overrides push and pop
//   head_data         head entry, zero while empty
//   count             number of valid entries
//   empty, full       occupancy flags
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rts,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        do_push = push && !flush && !full;
        do_pop  = pop && !flush && !empty;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                // DEPTH is a power of two, so pointer wrap is free
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front-end: PC, APB read sequencer, prefetch queue
//
// Ports:
//   clk, rts                       clock, synchronous active-high reset
//   bus_addr/sel/en                APB master request (address held for the transfer)
//   bus_rdata/ready/err            APB response
//   redirect_valid, redirect_pc    one-cycle pulse: load new PC and flush the queue
//   inst_valid/inst/inst_pc        queue head towards decode
//   inst_ready                     decode accepts the head
//   halted                         sticky, a zero instruction word was fetched
//   fetch_err                      sticky, a live fetch returned bus_err
//   misalign_trap                  only with FETCH_MISALIGN_TRAP_EN: sticky until the
//                                  next redirect, set by a misaligned redirect target
//
// Build option FETCH_MISALIGN_TRAP_EN: when undefined the low two bits of the redirect
// target are cleared and no misalign_trap port exists.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              DEPTH     = 4
) (
    input  logic            clk,
    input  logic            rts,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_sel,
    output logic            bus_en,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ready,
    input  logic            bus_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            halted,
    output logic            fetch_err
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            sel_q, sel_d;
    logic            en_q, en_d;
    logic            discard_q, discard_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;
    logic            misalign_hold;
    logic [XLEN-1:0] redir_pc;

    logic              q_push;
    logic              q_pop;
    logic [2*XLEN-1:0] q_head;
    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_full;
    logic              completing;
    logic              can_issue;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign redir_pc      = redirect_pc;
    assign misalign_hold = misalign_q;
    assign misalign_trap = misalign_q;
`else
    assign redir_pc      = redirect_pc & ~XLEN'(3);
    assign misalign_hold = 1'b0;
`endif

    assign completing = (state_q == ACCESS) && bus_ready;

    // The queue slot is reserved at issue; only one transfer is ever in flight and
    // the queue only drains meanwhile, so a completion always finds room.
    // No issue on a redirect cycle: the new PC is not loaded yet.
    assign can_issue = !halted_q && !err_q && !misalign_hold && !redirect_valid &&
                       (q_count < CW'(DEPTH));

    // Redirect beats a same-cycle pop: the head belongs to the old stream
    assign q_pop = inst_ready && !q_empty && !redirect_valid;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        halted_d  = halted_q;
        err_d     = err_q;
        q_push    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
        if (redirect_valid) begin
            misalign_d = |redirect_pc[1:0];
        end
`endif

        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = SETUP;
                    addr_d  = pc_q;
                    pc_d    = pc_q + XLEN'(FETCH_INC);
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A live completion either records an error, halts on a zero word, or queues
        if (completing && !discard_q && !redirect_valid) begin
            if (bus_err) begin
                err_d = 1'b1;
            end else if (bus_rdata == '0) begin
                halted_d = 1'b1;
            end else begin
                q_push = 1'b1;
            end
        end

        // A redirect never aborts the bus; the stale transfer runs out and is dropped
        if (completing) begin
            discard_d = 1'b0;
        end else if (redirect_valid && (state_q != IDLE)) begin
            discard_d = 1'b1;
        end

        if (redirect_valid) begin
            pc_d = redir_pc;
        end

        sel_d = (state_d != IDLE);
        en_d  = (state_d == ACCESS);
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            state_q   <= IDLE;
            pc_q      <= RESET_VEC;
            addr_q    <= '0;
            sel_q     <= 1'b0;
            en_q      <= 1'b0;
            discard_q <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            discard_q <= discard_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rts       (rts),
        .push      (q_push && !q_full),
        .push_data ({addr_q, bus_rdata}),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign bus_addr   = addr_q;
    assign bus_sel    = sel_q;
    assign bus_en     = en_q;
    assign inst_valid = !q_empty;
    assign inst_pc    = q_head[2*XLEN-1:XLEN];
    assign inst       = q_head[XLEN-1:0];
    assign halted     = halted_q;
    assign fetch_err  = err_q;

endmodule
